// File: rtl/pipe_stage_buf.sv
// In-order DEPTH-entry pipeline stage buffer carrying {hit, data} with valid/ready handshakes,
// freeze/flush control and saturating stall/squash statistics.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic                       in_hit_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_hit_o,
  input  logic                       freeze_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           squash_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
  localparam logic [SUM_W-1:0] SQ_MAX = SUM_W'({CNT_W{1'b1}});

  logic [WIDTH:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   squash_q, squash_d;
  logic               enq, deq, wr_en, stall_ev;
  logic [SUM_W-1:0]   sq_sum;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready_o  = !freeze_i && !flush_i && (count_q < OCC_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign enq         = in_valid_i && in_ready_o;
  assign deq         = out_valid_o && out_ready_i && !freeze_i && !flush_i;
  assign stall_ev    = in_valid_i && !in_ready_o && !flush_i;
  assign sq_sum      = SUM_W'(squash_q) + SUM_W'(count_q);

  assign out_data_o   = mem_q[head_q][WIDTH-1:0];
  assign out_hit_o    = mem_q[head_q][WIDTH];
  assign occupancy_o  = count_q;
  assign stall_cnt_o  = stall_q;
  assign squash_cnt_o = squash_q;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    stall_d  = stall_q;
    squash_d = squash_q;
    wr_en    = 1'b0;
    if (stall_ev && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    if (flush_i) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      squash_d = (sq_sum > SQ_MAX) ? '1 : sq_sum[CNT_W-1:0];
    end else if (!freeze_i) begin
      if (enq) begin
        wr_en  = 1'b1;
        tail_d = ptr_next(tail_q);
      end
      if (deq) begin
        head_d = ptr_next(head_q);
      end
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      stall_q  <= '0;
      squash_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      squash_q <= squash_d;
      if (wr_en) begin
        mem_q[tail_q] <= {in_hit_i, in_data_i};
      end
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage buffer: the successor to the fixed single-entry ID/EX latch. It carries an arbitrary-width payload plus a branch-predictor hit tag through a DEPTH-entry in-order buffer, using valid/ready handshakes, freeze (hold) and flush (squash). It also keeps saturating stall and squash counters for performance analysis. It instantiates between any two pipeline stages (IF/ID, ID/EX, EX/MEM); the hazard and predictor logic drives freeze and flush.

## Interface
Parameters:
- WIDTH, 32: payload bits per entry (≥1).
- DEPTH, 2: buffer entries (1..8). DEPTH ≥ 2 is required for one-per-cycle throughput.
- CNT_W, 16: width of the statistics counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  buffer accepts the entry this cycle (combinational).
- in_data  in  WIDTH  payload.
- in_hit  in  1  predictor hit tag for the payload.
- out_valid  out  1  head entry available.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  WIDTH  head payload.
- out_hit  out  1  head hit tag.
- freeze  in  1  hold all state; no enqueue, no dequeue.
- flush  in  1  squash all entries, including any enqueue this cycle.
- occupancy  out  $clog2(DEPTH+1)  entries held.
- stall_cnt  out  CNT_W  cycles in which upstream was blocked.
- squash_cnt  out  CNT_W  valid entries discarded by flush.

## Operation
- Storage: circular buffer of DEPTH entries, each {hit, data}, with head/tail pointers and a count.
  - Pointers wrap modulo DEPTH; non-power-of-two DEPTH wraps explicitly at DEPTH-1 → 0.
- Handshake signals:
  - in_ready = !freeze && !flush && (count < DEPTH).
  - out_valid = (count > 0).
- Transfer events:
  - enq = in_valid && in_ready.
  - deq = out_valid && out_ready && !freeze && !flush.
- out_data/out_hit are always the head entry, including when out_valid = 0 (stale, don't-care).
- Priority per edge: RST > flush > freeze > normal.
  - flush: count, head and tail go to 0; enq is suppressed; squash_cnt += count (saturating).
  - freeze (no flush): no pointer or count change; stall_cnt still counts.
  - normal: enq writes the tail and advances it; deq advances the head; count += enq − deq. Simultaneous enq and deq leave count unchanged.
- stall_cnt increments when in_valid && !in_ready && !flush, and saturates at 2^CNT_W−1.
- squash_cnt adds at most DEPTH per flush. If the sum would overflow, it clamps to 2^CNT_W−1.
- Ordering: strictly FIFO. The hit tag always stays paired with its payload.

## Timing
- Reset (async, any time, including mid-transfer):
  - count, pointers, storage, stall_cnt and squash_cnt go to 0.
  - out_valid = 0, occupancy = 0, out_data = 0, out_hit = 0.
  - in_ready = 1 unless freeze or flush is high.
- Latency: an entry enqueued at edge N is presented on out_data after edge N (usable in cycle N+1). There is no combinational bypass from in_data to out_data.
- Throughput:
  - DEPTH ≥ 2: one entry per cycle sustained when out_ready is held high.
  - DEPTH = 1: one entry every 2 cycles, because in_ready = 0 while full.
- Full: in_ready = 0 even if out_ready = 1 (no pass-through when full).
- Empty: out_ready is ignored and no deq occurs.
- flush and freeze together: flush wins.
- flush on an empty buffer: no state change except a stall_cnt update, which is not counted because flush is high.

## Test plan
- Reset then stream: RST pulse; push 0x11,0x22,0x33 on consecutive cycles with out_ready=1, DEPTH=2 → out_data 0x11,0x22,0x33 on cycles 1,2,3 after each push; occupancy never exceeds 1; stall_cnt=0.
- Fill/backpressure: out_ready=0, push 3 entries, DEPTH=2 → in_ready drops after the 2nd; stall_cnt increments 1 per blocked cycle; releasing out_ready drains 0x11,0x22 in order and the 3rd then enters.
- Freeze: with 2 entries held, freeze=1 for 4 cycles with in_valid=1 and out_ready=1 → occupancy stays 2, out_data unchanged, stall_cnt +4; after release, normal drain.
- Flush with simultaneous push: 2 entries held (hit=1,0), flush=1 and in_valid=1 in the same cycle → occupancy 0 next cycle, out_valid=0, squash_cnt=2, pushed entry absent.
- Wrap and saturation: DEPTH=3, CNT_W=2; run 10 entries through with random out_ready → order and hit tags preserved across pointer wrap; hold in_valid against a full buffer for 5 cycles → stall_cnt=3 (saturated).
- Async reset mid-operation: assert RST between edges with 2 entries held → out_valid and occupancy go 0 immediately, before the next edge.
